// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: ramps three fill-factor words toward a handshaked target colour, holds, then signals DONE.
module rgb_fade_sequencer #(
    parameter int FILL_FACTOR_MAX      = 255,
    parameter int FILL_FACTOR_BITS_NUM = $clog2(FILL_FACTOR_MAX),
    parameter int STEP                 = 1,
    parameter int HOLD_TICKS           = 0
) (
    input  logic                            CLK,
    input  logic                            CLR,
    input  logic                            CE,
    input  logic                            ABORT,
    input  logic                            IN_VALID,
    output logic                            IN_READY,
    input  logic [FILL_FACTOR_BITS_NUM-1:0] IN_R,
    input  logic [FILL_FACTOR_BITS_NUM-1:0] IN_G,
    input  logic [FILL_FACTOR_BITS_NUM-1:0] IN_B,
    output logic [FILL_FACTOR_BITS_NUM-1:0] R_FILL_FACTOR,
    output logic [FILL_FACTOR_BITS_NUM-1:0] G_FILL_FACTOR,
    output logic [FILL_FACTOR_BITS_NUM-1:0] B_FILL_FACTOR,
    output logic                            BUSY,
    output logic                            DONE
);
    localparam int W = FILL_FACTOR_BITS_NUM;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FADE = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [W-1:0] FF_MAX = W'(FILL_FACTOR_MAX);
    localparam logic [W:0] STEP_W = (W+1)'(STEP);
    localparam logic [W-1:0] STEP_V = W'(STEP);
    localparam logic [15:0] HOLD_V = 16'(HOLD_TICKS);

    logic [1:0] state;
    logic [15:0] hold_cnt;
    logic [2:0][W-1:0] cur, tgt, nxt, in_raw, in_c;
    logic at_tgt;

    // Signed difference keeps the step from overshooting or wrapping in either direction.
    function automatic logic [W-1:0] approach(input logic [W-1:0] c, input logic [W-1:0] t);
        logic signed [W:0] d;
        logic [W:0] mag;
        d = $signed({1'b0, t}) - $signed({1'b0, c});
        mag = d[W] ? $unsigned(-d) : $unsigned(d);
        return (mag <= STEP_W) ? t : (d[W] ? c - STEP_V : c + STEP_V);
    endfunction

    assign in_raw = {IN_B, IN_G, IN_R};
    for (genvar i = 0; i < 3; i++) begin : g_ch
        assign nxt[i] = approach(cur[i], tgt[i]);
        assign in_c[i] = (in_raw[i] > FF_MAX) ? FF_MAX : in_raw[i];
    end
    assign at_tgt = (cur == tgt);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= IDLE;
            cur <= '0;
            tgt <= '0;
            hold_cnt <= '0;
            DONE <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (ABORT) begin
                state <= IDLE;
                hold_cnt <= '0;
            end else if (state == IDLE) begin
                if (IN_VALID) begin
                    tgt <= in_c;
                    state <= FADE;
                end
            end else if (CE && state == FADE) begin
                if (at_tgt) begin
                    state <= (HOLD_TICKS == 0) ? IDLE : HOLD;
                    hold_cnt <= HOLD_V;
                    DONE <= (HOLD_TICKS == 0);
                end else begin
                    cur <= nxt;
                end
            end else if (CE && state == HOLD) begin
                hold_cnt <= hold_cnt - 16'd1;
                if (hold_cnt == 16'd1) begin
                    state <= IDLE;
                    DONE <= 1'b1;
                end
            end
        end
    end

    assign IN_READY = (state == IDLE);
    assign BUSY = (state != IDLE);
    assign R_FILL_FACTOR = cur[0];
    assign G_FILL_FACTOR = cur[1];
    assign B_FILL_FACTOR = cur[2];
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: random and directed stimulus checked against a cycle-level colour-fade model.
module tb_rgb_fade_sequencer;
    localparam int MAXV = 200;
    localparam int STEPV = 4;
    localparam int HOLDV = 3;

    logic CLK = 1'b0, CLR = 1'b0, CE = 1'b0, ABORT = 1'b0, IN_VALID = 1'b0;
    logic IN_READY, BUSY, DONE;
    logic [7:0] IN_R = '0, IN_G = '0, IN_B = '0;
    logic [7:0] R_FF, G_FF, B_FF;

    int vectors = 0, errors = 0;
    int ce_mode = 0, cyc = 0;
    bit chk_en = 1'b0;
    int m_mode, m_hold;
    int m_cur[3], m_tgt[3];
    bit m_done;

    rgb_fade_sequencer #(.FILL_FACTOR_MAX(MAXV), .STEP(STEPV), .HOLD_TICKS(HOLDV)) dut (
        .CLK(CLK), .CLR(CLR), .CE(CE), .ABORT(ABORT), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_R(IN_R), .IN_G(IN_G), .IN_B(IN_B),
        .R_FILL_FACTOR(R_FF), .G_FILL_FACTOR(G_FF), .B_FILL_FACTOR(B_FF),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return a < b ? a : b;
    endfunction

    always @(negedge CLK) begin
        cyc++;
        CE = (ce_mode == 0) ? 1'b1 : (ce_mode == 1) ? (cyc % 4 == 0) : ($urandom_range(3, 0) != 0);
    end

    // Model: mode 0 idle, 1 fading, 2 holding; channels move by min(STEP, distance).
    always @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            m_mode = 0; m_hold = 0; m_done = 0;
            for (int i = 0; i < 3; i++) begin m_cur[i] = 0; m_tgt[i] = 0; end
        end else begin
            int in_v[3];
            bit same;
            in_v[0] = IN_R; in_v[1] = IN_G; in_v[2] = IN_B;
            m_done = 0;
            same = 1;
            for (int i = 0; i < 3; i++) if (m_cur[i] != m_tgt[i]) same = 0;
            if (ABORT) begin
                m_mode = 0; m_hold = 0;
            end else if (m_mode == 0) begin
                if (IN_VALID) begin
                    for (int i = 0; i < 3; i++) m_tgt[i] = imin(in_v[i], MAXV);
                    m_mode = 1;
                end
            end else if (CE && m_mode == 1) begin
                if (same) begin
                    if (HOLDV == 0) begin m_mode = 0; m_done = 1; end
                    else begin m_mode = 2; m_hold = HOLDV; end
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        int d;
                        d = m_tgt[i] - m_cur[i];
                        m_cur[i] += (d > 0) ? imin(STEPV, d) : -imin(STEPV, -d);
                    end
                end
            end else if (CE && m_mode == 2) begin
                m_hold--;
                if (m_hold == 0) begin m_mode = 0; m_done = 1; end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("r", int'(R_FF), m_cur[0]);
            check("g", int'(G_FF), m_cur[1]);
            check("b", int'(B_FF), m_cur[2]);
            check("in_ready", int'(IN_READY), int'(m_mode == 0));
            check("busy", int'(BUSY), int'(m_mode != 0));
            check("done", int'(DONE), int'(m_done));
        end
    end

    task automatic send(input int r, input int g, input int b);
        int n = 0;
        while (!IN_READY && n < 1000) begin @(negedge CLK); n++; end
        check("ready_timeout", int'(n >= 1000), 0);
        IN_VALID = 1'b1; IN_R = 8'(r); IN_G = 8'(g); IN_B = 8'(b);
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin @(negedge CLK); k++; end while (!DONE && k < 2000);
        check("done_seen", int'(DONE), 1);
    endtask

    initial begin
        int k, n;
        repeat (3) @(negedge CLK);
        check("rst_r", int'(R_FF), 0);
        check("rst_b", int'(B_FF), 0);
        check("rst_ready", int'(IN_READY), 1);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        CLR = 1'b1;
        chk_en = 1'b1;
        @(negedge CLK);

        send(10, 0, 255);
        check("acc_busy", int'(BUSY), 1);
        check("acc_r0", int'(R_FF), 0);
        @(negedge CLK); check("ramp_r4", int'(R_FF), 4);
        @(negedge CLK); check("ramp_r8", int'(R_FF), 8);
        @(negedge CLK); check("ramp_r10", int'(R_FF), 10);
        wait_done(k);
        check("ramp_len", k, 51);
        check("clamp_b", int'(B_FF), 200);
        check("ramp_g", int'(G_FF), 0);

        send(200, 200, 200);
        wait_done(k);
        send(0, 100, 200);
        check("b2b_busy", int'(BUSY), 1);
        @(negedge CLK);
        check("down_r", int'(R_FF), 196);
        check("down_g", int'(G_FF), 196);
        wait_done(k);
        check("down_len", k, 53);
        check("down_final_g", int'(G_FF), 100);

        ce_mode = 1;
        send(20, 20, 20);
        check("gated_busy", int'(BUSY), 1);
        wait_done(k);
        check("gated_r", int'(R_FF), 20);

        ce_mode = 0;
        send(0, 0, 0);
        wait_done(k);
        send(100, 0, 0);
        repeat (10) @(negedge CLK);
        check("abort_pre_r", int'(R_FF), 40);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_ready", int'(IN_READY), 1);
        check("abort_r", int'(R_FF), 40);
        check("abort_done", int'(DONE), 0);
        ABORT = 1'b1; IN_VALID = 1'b1; IN_R = 8'd77;
        @(negedge CLK);
        ABORT = 1'b0; IN_VALID = 1'b0;
        check("abort_valid_ready", int'(IN_READY), 1);
        check("abort_valid_busy", int'(BUSY), 0);
        send(0, 0, 0);
        @(negedge CLK);
        check("restart_r", int'(R_FF), 36);
        wait_done(k);

        ce_mode = 2;
        IN_VALID = 1'b1;
        repeat (600) begin
            @(negedge CLK);
            IN_R = 8'($urandom_range(255, 0));
            IN_G = 8'($urandom_range(255, 0));
            IN_B = 8'($urandom_range(255, 0));
            ABORT = ($urandom_range(39, 0) == 0);
        end
        IN_VALID = 1'b0; ABORT = 1'b0;

        ce_mode = 0;
        send(150, 60, 90);
        n = 0;
        while (m_mode != 2 && n < 1000) begin @(negedge CLK); n++; end
        check("hold_reached", int'(m_mode), 2);
        #2 CLR = 1'b0;
        #1;
        check("async_r", int'(R_FF), 0);
        check("async_g", int'(G_FF), 0);
        check("async_ready", int'(IN_READY), 1);
        check("async_busy", int'(BUSY), 0);
        @(negedge CLK);
        CLR = 1'b1;
        repeat (3) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
